// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester command/response ports plus the ALU-facing bus of alu_arbiter.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int STATUS_WIDTH = 5
);
  logic                    i_req0_valid, i_req1_valid;
  logic                    o_req0_ready, o_req1_ready;
  logic [DATA_WIDTH-1:0]   i_req0_a, i_req0_b, i_req1_a, i_req1_b;
  logic [3:0]              i_req0_opcode, i_req1_opcode;
  logic                    o_rsp0_valid, o_rsp1_valid;
  logic                    i_rsp0_ready, i_rsp1_ready;
  logic [DATA_WIDTH-1:0]   o_rsp_c;
  logic [STATUS_WIDTH-1:0] o_rsp_status;
  logic                    o_rsp_err;
  logic [DATA_WIDTH-1:0]   o_alu_a, o_alu_b;
  logic [3:0]              o_alu_opcode;
  logic                    o_alu_enable;
  logic [DATA_WIDTH-1:0]   i_alu_c;
  logic [STATUS_WIDTH-1:0] i_alu_status;
  logic                    o_busy;
  modport slave (
    input  i_req0_valid, i_req1_valid, i_req0_a, i_req0_b, i_req1_a, i_req1_b,
           i_req0_opcode, i_req1_opcode, i_rsp0_ready, i_rsp1_ready, i_alu_c, i_alu_status,
    output o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid, o_rsp_c, o_rsp_status,
           o_rsp_err, o_alu_a, o_alu_b, o_alu_opcode, o_alu_enable, o_busy
  );
  modport master (
    output i_req0_valid, i_req1_valid, i_req0_a, i_req0_b, i_req1_a, i_req1_b,
           i_req0_opcode, i_req1_opcode, i_rsp0_ready, i_rsp1_ready, i_alu_c, i_alu_status,
    input  o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid, o_rsp_c, o_rsp_status,
           o_rsp_err, o_alu_a, o_alu_b, o_alu_opcode, o_alu_enable, o_busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters,
// one registered operation in flight (IDLE -> EXEC -> RESP).
module alu_arbiter #(
  parameter int DATA_WIDTH    = 16,
  parameter int STATUS_WIDTH  = 5,
  parameter int NUM_LEGAL_OPS = 12
) (
  input logic          i_clk,
  input logic          i_reset,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t                  r_state, w_next;
  logic                    r_last, r_gnt, r_err;
  logic [DATA_WIDTH-1:0]   r_a, r_b, r_c;
  logic [3:0]              r_op;
  logic [STATUS_WIDTH-1:0] r_status;
  logic                    w_any, w_gnt, w_legal, w_rsp_ready, w_accept;
  assign w_any       = bus.i_req0_valid | bus.i_req1_valid;
  // Contest goes to whoever was not served last; a lone requester always wins.
  assign w_gnt       = (bus.i_req0_valid & bus.i_req1_valid) ? ~r_last : bus.i_req1_valid;
  assign w_accept    = (r_state == IDLE) & w_any;
  assign w_legal     = r_op < 4'(NUM_LEGAL_OPS);
  assign w_rsp_ready = r_gnt ? bus.i_rsp1_ready : bus.i_rsp0_ready;
  always_comb begin
    w_next = (r_state == IDLE) ? (w_any ? EXEC : IDLE) :
             (r_state == EXEC) ? RESP :
             (w_rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last   <= 1'b1;
      r_gnt    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_c      <= '0;
      r_status <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_gnt <= w_gnt;
        r_a   <= w_gnt ? bus.i_req1_a : bus.i_req0_a;
        r_b   <= w_gnt ? bus.i_req1_b : bus.i_req0_b;
        r_op  <= w_gnt ? bus.i_req1_opcode : bus.i_req0_opcode;
      end
      if (r_state == EXEC) begin
        r_c      <= w_legal ? bus.i_alu_c : '0;
        r_status <= w_legal ? bus.i_alu_status : '0;
        r_err    <= ~w_legal;
      end
      if ((r_state == RESP) && w_rsp_ready) r_last <= r_gnt;
    end
  end
  assign bus.o_req0_ready = w_accept & ~w_gnt;
  assign bus.o_req1_ready = w_accept & w_gnt;
  assign bus.o_rsp0_valid = (r_state == RESP) & ~r_gnt;
  assign bus.o_rsp1_valid = (r_state == RESP) & r_gnt;
  assign bus.o_rsp_c      = r_c;
  assign bus.o_rsp_status = r_status;
  assign bus.o_rsp_err    = r_err;
  assign bus.o_alu_a      = r_a;
  assign bus.o_alu_b      = r_b;
  assign bus.o_alu_opcode = r_op;
  assign bus.o_alu_enable = (r_state == EXEC) & w_legal;
  assign bus.o_busy       = r_state != IDLE;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios against alu_arbiter with a tiny ALU stand-in (ADD, SUB, junk on illegal).
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  alu_arbiter_if #(.DATA_WIDTH(16), .STATUS_WIDTH(5)) bus ();
  alu_arbiter dut (.i_clk(clk), .i_reset(rst), .bus(bus));
  always #5 clk = ~clk;
  logic        alu_cy;
  logic [15:0] alu_c;
  // ADD: A+B; SUB: B-A with borrow; anything illegal returns junk so leaks are visible.
  always_comb begin
    {alu_cy, alu_c} = (bus.o_alu_opcode == 4'd0) ? {1'b0, bus.o_alu_a} + {1'b0, bus.o_alu_b} :
                      (bus.o_alu_opcode == 4'd3) ? {1'b0, bus.o_alu_b} - {1'b0, bus.o_alu_a} :
                      {1'b0, 16'hDEAD};
    bus.i_alu_c      = alu_c;
    bus.i_alu_status = (bus.o_alu_opcode >= 4'd12) ? 5'h1F :
                       {alu_c[15], alu_c == 16'd0, 1'b0,
                        (bus.o_alu_opcode == 4'd3) && (bus.o_alu_a > bus.o_alu_b), alu_cy};
  end
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic idle_inputs();
    bus.i_req0_valid = 0; bus.i_req1_valid = 0;
    bus.i_req0_a = 0; bus.i_req0_b = 0; bus.i_req0_opcode = 0;
    bus.i_req1_a = 0; bus.i_req1_b = 0; bus.i_req1_opcode = 0;
    bus.i_rsp0_ready = 0; bus.i_rsp1_ready = 0;
  endtask
  task automatic do_reset();
    rst = 1; cyc(); cyc(); rst = 0; #1;
  endtask
  task automatic test_reset();
    idle_inputs();
    do_reset();
    total++; if ({bus.o_req0_ready, bus.o_req1_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", {bus.o_req0_ready, bus.o_req1_ready}); end
    total++; if ({bus.o_rsp0_valid, bus.o_rsp1_valid, bus.o_alu_enable, bus.o_busy} !== 4'b0) begin bad++; $display("FAIL reset_ctl got=%b want=0000", {bus.o_rsp0_valid, bus.o_rsp1_valid, bus.o_alu_enable, bus.o_busy}); end
    total++; if ({bus.o_rsp_c, bus.o_rsp_status, bus.o_rsp_err} !== 22'd0) begin bad++; $display("FAIL reset_rsp got=%h want=0", {bus.o_rsp_c, bus.o_rsp_status, bus.o_rsp_err}); end
    total++; if ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_opcode} !== 36'd0) begin bad++; $display("FAIL reset_alu got=%h want=0", {bus.o_alu_a, bus.o_alu_b, bus.o_alu_opcode}); end
  endtask
  task automatic test_add0();
    bus.i_req0_valid = 1; bus.i_req0_a = 3; bus.i_req0_b = 4; bus.i_req0_opcode = 0; #1;
    total++; if ({bus.o_req0_ready, bus.o_req1_ready} !== 2'b10) begin bad++; $display("FAIL add_ready got=%b want=10", {bus.o_req0_ready, bus.o_req1_ready}); end
    cyc(); bus.i_req0_valid = 0; #1;
    total++; if ({bus.o_alu_enable, bus.o_busy, bus.o_rsp0_valid, bus.o_req0_ready} !== 4'b1100) begin bad++; $display("FAIL add_exec got=%b want=1100", {bus.o_alu_enable, bus.o_busy, bus.o_rsp0_valid, bus.o_req0_ready}); end
    cyc();
    total++; if ({bus.o_rsp0_valid, bus.o_rsp1_valid} !== 2'b10) begin bad++; $display("FAIL add_rspvalid got=%b want=10", {bus.o_rsp0_valid, bus.o_rsp1_valid}); end
    total++; if (bus.o_rsp_c !== 16'd7) begin bad++; $display("FAIL add_c got=%h want=0007", bus.o_rsp_c); end
    total++; if ({bus.o_rsp_status, bus.o_rsp_err} !== 6'd0) begin bad++; $display("FAIL add_status got=%b want=000000", {bus.o_rsp_status, bus.o_rsp_err}); end
    bus.i_rsp0_ready = 1; cyc(); bus.i_rsp0_ready = 0; #1;
    total++; if ({bus.o_busy, bus.o_rsp0_valid} !== 2'b00) begin bad++; $display("FAIL add_done got=%b want=00", {bus.o_busy, bus.o_rsp0_valid}); end
  endtask
  task automatic test_sub1();
    bus.i_req1_valid = 1; bus.i_req1_a = 5; bus.i_req1_b = 3; bus.i_req1_opcode = 3; #1;
    total++; if ({bus.o_req0_ready, bus.o_req1_ready} !== 2'b01) begin bad++; $display("FAIL sub_ready got=%b want=01", {bus.o_req0_ready, bus.o_req1_ready}); end
    cyc(); bus.i_req1_valid = 0; #1;
    total++; if (bus.o_alu_enable !== 1'b1) begin bad++; $display("FAIL sub_en_exec got=%b want=1", bus.o_alu_enable); end
    cyc();
    total++; if (bus.o_alu_enable !== 1'b0) begin bad++; $display("FAIL sub_en_resp got=%b want=0", bus.o_alu_enable); end
    total++; if ({bus.o_rsp0_valid, bus.o_rsp1_valid} !== 2'b01) begin bad++; $display("FAIL sub_rspvalid got=%b want=01", {bus.o_rsp0_valid, bus.o_rsp1_valid}); end
    total++; if ({bus.o_rsp_c, bus.o_rsp_status} !== {16'hFFFE, 5'h13}) begin bad++; $display("FAIL sub_result got=%h/%h want=fffe/13", bus.o_rsp_c, bus.o_rsp_status); end
    bus.i_rsp1_ready = 1; cyc(); bus.i_rsp1_ready = 0; #1;
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL sub_done got=%b want=0", bus.o_busy); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    bus.i_req0_valid = 1; bus.i_req0_a = 1; bus.i_req0_b = 1; bus.i_req0_opcode = 0;
    bus.i_req1_valid = 1; bus.i_req1_a = 2; bus.i_req1_b = 2; bus.i_req1_opcode = 0;
    bus.i_rsp0_ready = 1; bus.i_rsp1_ready = 1; #1;
    for (int k = 0; k < 4; k++) begin
      total++; if ({bus.o_busy, bus.o_req0_ready, bus.o_req1_ready} !== {1'b0, k[0] == 1'b0, k[0]}) begin bad++; $display("FAIL b2b_grant%0d got=%b want=0%b%b", k, {bus.o_busy, bus.o_req0_ready, bus.o_req1_ready}, k[0] == 1'b0, k[0]); end
      cyc(); cyc();
      total++; if ({bus.o_rsp0_valid, bus.o_rsp1_valid, bus.o_rsp_c} !== {k[0] == 1'b0, k[0], k[0] ? 16'd4 : 16'd2}) begin bad++; $display("FAIL b2b_rsp%0d got=%b%b/%h", k, bus.o_rsp0_valid, bus.o_rsp1_valid, bus.o_rsp_c); end
      cyc();
    end
    idle_inputs(); #1;
  endtask
  task automatic test_stall();
    bus.i_req0_valid = 1; bus.i_req0_a = 10; bus.i_req0_b = 20; bus.i_req0_opcode = 0;
    bus.i_req1_valid = 1; bus.i_req1_opcode = 0; #1;
    total++; if (bus.o_req0_ready !== 1'b1) begin bad++; $display("FAIL stall_grant got=%b want=1", bus.o_req0_ready); end
    cyc(); bus.i_req0_valid = 0; cyc();
    for (int k = 0; k < 5; k++) begin
      total++; if ({bus.o_rsp0_valid, bus.o_busy, bus.o_req1_ready, bus.o_rsp_c, bus.o_rsp_status, bus.o_rsp_err} !== {3'b110, 16'd30, 5'd0, 1'b0}) begin bad++; $display("FAIL stall_hold%0d got v=%b busy=%b r1=%b c=%h st=%h", k, bus.o_rsp0_valid, bus.o_busy, bus.o_req1_ready, bus.o_rsp_c, bus.o_rsp_status); end
      cyc();
    end
    bus.i_rsp0_ready = 1; cyc(); bus.i_rsp0_ready = 0; #1;
    total++; if ({bus.o_busy, bus.o_rsp0_valid, bus.o_req1_ready} !== 3'b001) begin bad++; $display("FAIL stall_release got=%b want=001", {bus.o_busy, bus.o_rsp0_valid, bus.o_req1_ready}); end
    bus.i_req1_valid = 0; #1;
  endtask
  task automatic test_illegal();
    bus.i_req0_valid = 1; bus.i_req0_a = 1; bus.i_req0_b = 2; bus.i_req0_opcode = 13;
    cyc(); bus.i_req0_valid = 0; #1;
    total++; if ({bus.o_busy, bus.o_alu_enable} !== 2'b10) begin bad++; $display("FAIL ill_exec got=%b want=10", {bus.o_busy, bus.o_alu_enable}); end
    cyc();
    total++; if ({bus.o_rsp0_valid, bus.o_alu_enable, bus.o_rsp_err, bus.o_rsp_c, bus.o_rsp_status} !== {3'b101, 21'd0}) begin bad++; $display("FAIL ill_rsp got v=%b en=%b err=%b c=%h st=%h", bus.o_rsp0_valid, bus.o_alu_enable, bus.o_rsp_err, bus.o_rsp_c, bus.o_rsp_status); end
    bus.i_rsp0_ready = 1; cyc(); bus.i_rsp0_ready = 0;
    bus.i_req0_valid = 1; bus.i_req0_a = 2; bus.i_req0_b = 2; bus.i_req0_opcode = 0;
    cyc(); bus.i_req0_valid = 0; cyc();
    total++; if ({bus.o_rsp0_valid, bus.o_rsp_err, bus.o_rsp_c} !== {2'b10, 16'd4}) begin bad++; $display("FAIL ill_next got v=%b err=%b c=%h", bus.o_rsp0_valid, bus.o_rsp_err, bus.o_rsp_c); end
    bus.i_rsp0_ready = 1; cyc(); bus.i_rsp0_ready = 0; #1;
  endtask
  task automatic test_reset_inflight();
    bus.i_req0_valid = 1; bus.i_req0_a = 9; bus.i_req0_b = 9; bus.i_req0_opcode = 0;
    cyc(); bus.i_req0_valid = 0; rst = 1; cyc(); rst = 0; #1;
    total++; if ({bus.o_busy, bus.o_rsp0_valid, bus.o_rsp1_valid, bus.o_alu_enable} !== 4'b0) begin bad++; $display("FAIL rst_exec_ctl got=%b want=0000", {bus.o_busy, bus.o_rsp0_valid, bus.o_rsp1_valid, bus.o_alu_enable}); end
    total++; if ({bus.o_alu_a, bus.o_alu_opcode, bus.o_rsp_c, bus.o_rsp_err} !== 37'd0) begin bad++; $display("FAIL rst_exec_data got a=%h op=%h c=%h err=%b", bus.o_alu_a, bus.o_alu_opcode, bus.o_rsp_c, bus.o_rsp_err); end
    bus.i_req1_valid = 1; bus.i_req1_a = 7; bus.i_req1_b = 1; bus.i_req1_opcode = 0;
    cyc(); bus.i_req1_valid = 0; cyc();
    total++; if (bus.o_rsp1_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_resp got=%b want=1", bus.o_rsp1_valid); end
    rst = 1; cyc(); rst = 0; #1;
    total++; if ({bus.o_busy, bus.o_rsp1_valid, bus.o_rsp_c, bus.o_rsp_status} !== 23'd0) begin bad++; $display("FAIL rst_resp got busy=%b v=%b c=%h st=%h", bus.o_busy, bus.o_rsp1_valid, bus.o_rsp_c, bus.o_rsp_status); end
    bus.i_req0_valid = 1; bus.i_req1_valid = 1; #1;
    total++; if ({bus.o_req0_ready, bus.o_req1_ready} !== 2'b10) begin bad++; $display("FAIL rst_contest got=%b want=10", {bus.o_req0_ready, bus.o_req1_ready}); end
    idle_inputs();
  endtask
  initial begin
    test_reset();
    test_add0();
    test_sub1();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational CR16 ALU between two requesters, e.g. requester 0 = datapath execute stage, requester 1 = address/branch-offset unit.
- Each requester uses a valid/ready command port and a valid/ready response port.
- Round-robin arbitration, registered operands and registered results; one operation in flight at a time.
- Drives the ALU through explicit ALU-facing ports. The ALU stays a separate instance beside this block.

Parameters:
- DATA_WIDTH, 16, operand/result width
- STATUS_WIDTH, 5, ALU status width: [0] carry, [1] low, [2] flag/overflow, [3] zero, [4] negative
- NUM_LEGAL_OPS, 12, opcodes 0..NUM_LEGAL_OPS-1 are legal (ADD..ARSH); others are illegal

Ports:
- I_CLK  in  1  system clock
- I_RESET  in  1  synchronous, active-high reset
- I_REQ0_VALID, I_REQ1_VALID  in  1 each  command valid
- O_REQ0_READY, O_REQ1_READY  out  1 each  command accepted this cycle
- I_REQ0_A, I_REQ0_B, I_REQ1_A, I_REQ1_B  in  DATA_WIDTH each  operands
- I_REQ0_OPCODE, I_REQ1_OPCODE  in  4 each  ALU opcode
- O_RSP0_VALID, O_RSP1_VALID  out  1 each  result valid
- I_RSP0_READY, I_RSP1_READY  in  1 each  result consumed
- O_RSP_C  out  DATA_WIDTH  result, shared by both response ports
- O_RSP_STATUS  out  STATUS_WIDTH  flags, shared by both response ports
- O_RSP_ERR  out  1  illegal opcode
- O_ALU_A, O_ALU_B  out  DATA_WIDTH each  to ALU I_A / I_B
- O_ALU_OPCODE  out  4  to ALU I_OPCODE
- O_ALU_ENABLE  out  1  to ALU I_ENABLE
- I_ALU_C  in  DATA_WIDTH  from ALU O_C
- I_ALU_STATUS  in  STATUS_WIDTH  from ALU O_STATUS
- O_BUSY  out  1  state != IDLE

Behaviour:
- Clocking: everything is on the rising edge of I_CLK. I_RESET is synchronous, active-high, and overrides all other inputs.
- Reset values:
  - state=IDLE, last_grant=1 (so requester 0 wins first)
  - all O_*_VALID/READY = 0, O_ALU_ENABLE = 0, O_BUSY = 0
  - O_RSP_C = 0, O_RSP_STATUS = 0, O_RSP_ERR = 0
  - O_ALU_A/B/OPCODE = 0
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant goes to the requester with VALID high.
  - If both are valid, the requester != last_grant wins.
  - O_REQg_READY is combinational: high in IDLE only for the granted requester. The losing requester sees READY=0.
  - On the handshake: latch A, B, OPCODE and grant id g; go to EXEC.
  - If neither is valid, stay in IDLE.
- EXEC (exactly 1 cycle):
  - O_ALU_A/B/OPCODE are driven from the latched registers.
  - O_ALU_ENABLE=1 only if the opcode is legal.
  - At end of cycle, capture I_ALU_C to O_RSP_C and I_ALU_STATUS to O_RSP_STATUS, with ERR=0.
  - Illegal opcode: capture C=0, STATUS=0, ERR=1; ALU enable stays 0.
  - Go to RESP.
- RESP:
  - O_RSPg_VALID=1. The other response valid stays 0.
  - O_RSP_C, O_RSP_STATUS and O_RSP_ERR are held stable until the handshake.
  - On I_RSPg_READY: set last_grant=g and go to IDLE.
  - No new command is accepted while in RESP.
- Outside EXEC, O_ALU_ENABLE=0; O_ALU_A/B/OPCODE keep their last value.
- Latency: command handshake at cycle N -> response valid from cycle N+2.
  - Minimum 3 cycles per operation when I_RSP_READY is held high.
- No bypass: a command offered during RESP waits for IDLE.
- Fairness: while both requesters are continuously valid, grants strictly alternate 0,1,0,1...
- Operand convention is the ALU's, passed through unmodified. SUB yields B-A; the carry/low semantics are the ALU's.
- The arbiter performs no arithmetic; width is DATA_WIDTH end to end.
- Reset at any state: the in-flight operation is dropped with no response, the FSM returns to IDLE and last_grant=1.
- Response VALID never deasserts before its READY, and VALID never depends combinationally on READY.

Test Plan:
- Reset, then REQ0 ADD (opcode 0) A=3 B=4 -> READY0 pulse at N; RSP0_VALID at N+2; C=16'd7; STATUS[3]=0, STATUS[4]=0; ERR=0; RSP1_VALID stays 0.
- REQ1 SUB (opcode 3) A=5 B=3 -> C=16'hFFFE, STATUS[4]=1, STATUS[1]=1; O_ALU_ENABLE high for exactly one cycle.
- Both valid continuously for 4 ops, RSP ready high -> grant order 0,1,0,1, one op per 3 cycles; the first grant after reset goes to requester 0.
- RSP0_READY held low for 5 cycles in RESP -> C, STATUS and VALID stable; REQ1_READY stays 0; IDLE reached only after READY.
- REQ0 opcode 13 -> ERR=1, C=0, STATUS=0, O_ALU_ENABLE never asserted; the next legal op returns ERR=0.
- I_RESET asserted during EXEC and again during RESP -> no RSP_VALID; next cycle IDLE with all outputs at reset values; REQ0 wins the next contest.
